axis_udp_tx: RTL and testbench

AXIS_UDP_TX -- requirements
Module: axis_udp_tx

---
 rtl/axis_udp_pkg.sv | 37 +++
 rtl/ipv4_csum.sv | 50 +++++
 rtl/axis_udp_tx.sv | 199 +++++++++++++++++++
 tb/tb_axis_udp_tx.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_udp_pkg.sv
// Shared definitions for the UDP frame transmitter: bus widths, frame
// header constants, FSM state encoding and a byte-order helper.
package axis_udp_pkg;

   localparam int AXIS_DATA_WIDTH = 64;
   localparam int AXIS_STRB_WIDTH = AXIS_DATA_WIDTH / 8;
   localparam int HDR_BYTES       = 42;

   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_VER_IHL     = 8'h45;
   localparam logic [7:0]  IP_TOS         = 8'h00;
   localparam logic [15:0] IP_FLAGS_FRAG  = 16'h4000;
   localparam logic [7:0]  IP_TTL         = 8'd64;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
   localparam logic [15:0] UDP_CSUM       = 16'h0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CSUM0,
      ST_CSUM1,
      ST_HDR,
      ST_MIX,
      ST_PAY,
      ST_TAIL
   } state_t;

   // Header is assembled MSB-first (network order); the wire puts byte 0 on
   // tdata[7:0], so reverse byte order once and slice 64-bit words out of it.
   function automatic logic [HDR_BYTES*8-1:0] hdr_to_wire(input logic [HDR_BYTES*8-1:0] be);
      logic [HDR_BYTES*8-1:0] le;
      for (int i = 0; i < HDR_BYTES; i++) begin
         le[8*i +: 8] = be[8*(HDR_BYTES-1-i) +: 8];
      end
      return le;
   endfunction

endpackage

// File: rtl/ipv4_csum.sv
// IPv4 header checksum, two pipelined cycles.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   sum_en          cycle 1: register the 20-bit sum of the ten halfwords
//   fold_en         cycle 2: fold carries, complement, register result
//   total_len, ip_id, src_ip, dst_ip   variable header fields
//   csum            checksum (valid after fold_en cycle)
module ipv4_csum
   import axis_udp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sum_en,
   input  logic        fold_en,
   input  logic [15:0] total_len,
   input  logic [15:0] ip_id,
   input  logic [31:0] src_ip,
   input  logic [31:0] dst_ip,
   output logic [15:0] csum
);

   logic [19:0] sum_d;
   logic [19:0] sum_q;
   logic [16:0] fold1;
   logic [15:0] fold2;

   // Checksum field itself is taken as zero, so it does not appear here.
   always_comb begin
      sum_d = {4'd0, IP_VER_IHL, IP_TOS} + {4'd0, total_len} + {4'd0, ip_id}
            + {4'd0, IP_FLAGS_FRAG} + {4'd0, IP_TTL, IP_PROTO_UDP}
            + {4'd0, src_ip[31:16]} + {4'd0, src_ip[15:0]}
            + {4'd0, dst_ip[31:16]} + {4'd0, dst_ip[15:0]};
   end

   // Ten halfwords carry at most 4 bits; after one fold a second carry can
   // only occur when the low half is tiny, so the second add cannot overflow.
   assign fold1 = {1'b0, sum_q[15:0]} + {13'd0, sum_q[19:16]};
   assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
         csum  <= '0;
      end else begin
         if (sum_en)  sum_q <= sum_d;
         if (fold_en) csum  <= ~fold2;
      end
   end

endmodule

// File: rtl/axis_udp_tx.sv
// Ethernet II / IPv4 / UDP frame transmitter. Prepends a 42-byte header to
// an AXI-Stream payload of N 64-bit words; the 2-byte header tail shifts the
// payload, so each output word mixes two payload words.
// Ports:
//   clk_i, arst_n_i             clock, async active-low reset
//   tx_start_i, len_words_i     frame request and payload length (words)
//   *_mac_i, *_ip_i, *_port_i, ip_id_i   header fields, captured at start
//   s_axis_*                    payload in (tstrb ignored)
//   m_axis_*                    frame out, registered
//   busy_o, len_err_o, start_err_o       status / error pulses
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | waiting for tx_start_i
// ST_CSUM0 | checksum sum stage
// ST_CSUM1 | checksum fold stage
// ST_HDR   | output header words 0..4
// ST_MIX   | output header bytes 40-41 + payload word 0 bytes 0-5
// ST_PAY   | output previous bytes 6-7 + current bytes 0-5
// ST_TAIL  | output last 2 bytes, wait for its handshake
module axis_udp_tx
   import axis_udp_pkg::*;
#(
   parameter int MAX_PAYLOAD_WORDS = 182
) (
   input  logic                       clk_i,
   input  logic                       arst_n_i,
   input  logic                       tx_start_i,
   input  logic [7:0]                 len_words_i,
   input  logic [47:0]                src_mac_i,
   input  logic [47:0]                dst_mac_i,
   input  logic [31:0]                src_ip_i,
   input  logic [31:0]                dst_ip_i,
   input  logic [15:0]                src_port_i,
   input  logic [15:0]                dst_port_i,
   input  logic [15:0]                ip_id_i,
   input  logic                       s_axis_tvalid,
   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [AXIS_STRB_WIDTH-1:0] s_axis_tstrb,
   input  logic                       s_axis_tlast,
   output logic                       s_axis_tready,
   output logic                       m_axis_tvalid,
   output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [AXIS_STRB_WIDTH-1:0] m_axis_tstrb,
   output logic                       m_axis_tlast,
   input  logic                       m_axis_tready,
   output logic                       busy_o,
   output logic                       len_err_o,
   output logic                       start_err_o
);

   localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD_WORDS);

   state_t                 state;
   logic [47:0]            src_mac_q, dst_mac_q;
   logic [31:0]            src_ip_q, dst_ip_q;
   logic [15:0]            src_port_q, dst_port_q, ip_id_q;
   logic [7:0]             len_q;
   logic [7:0]             pay_rem;
   logic [2:0]             hdr_idx;
   logic [15:0]            prev_q;
   logic [15:0]            tot_len, udp_len, csum;
   logic [HDR_BYTES*8-1:0] hdr_le;
   logic [AXIS_DATA_WIDTH-1:0] hdr_word;
   logic                   adv, pay_fire, pay_last;
   logic                   unused_strb;

   // Payload is word-granular; its byte enables carry no information.
   assign unused_strb = ^s_axis_tstrb;

   assign tot_len = 16'd28 + {5'd0, len_q, 3'd0};
   assign udp_len = 16'd8  + {5'd0, len_q, 3'd0};

   assign hdr_le = hdr_to_wire({dst_mac_q, src_mac_q, ETHERTYPE_IPV4, IP_VER_IHL, IP_TOS,
                                tot_len, ip_id_q, IP_FLAGS_FRAG, IP_TTL, IP_PROTO_UDP, csum,
                                src_ip_q, dst_ip_q, src_port_q, dst_port_q, udp_len, UDP_CSUM});

   always_comb begin
      case (hdr_idx)
         3'd0:    hdr_word = hdr_le[63:0];
         3'd1:    hdr_word = hdr_le[127:64];
         3'd2:    hdr_word = hdr_le[191:128];
         3'd3:    hdr_word = hdr_le[255:192];
         default: hdr_word = hdr_le[319:256];
      endcase
   end

   assign adv           = m_axis_tready | ~m_axis_tvalid;
   assign s_axis_tready = ((state == ST_MIX) || (state == ST_PAY)) && adv;
   assign pay_fire      = s_axis_tvalid & s_axis_tready;
   assign pay_last      = (pay_rem == 8'd1);

   ipv4_csum u_csum (
      .clk       (clk_i),
      .rst_n     (arst_n_i),
      .sum_en    (state == ST_CSUM0),
      .fold_en   (state == ST_CSUM1),
      .total_len (tot_len),
      .ip_id     (ip_id_q),
      .src_ip    (src_ip_q),
      .dst_ip    (dst_ip_q),
      .csum      (csum)
   );

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state         <= ST_IDLE;
         src_mac_q     <= '0;
         dst_mac_q     <= '0;
         src_ip_q      <= '0;
         dst_ip_q      <= '0;
         src_port_q    <= '0;
         dst_port_q    <= '0;
         ip_id_q       <= '0;
         len_q         <= '0;
         pay_rem       <= '0;
         hdr_idx       <= '0;
         prev_q        <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tstrb  <= '0;
         m_axis_tlast  <= 1'b0;
         busy_o        <= 1'b0;
         len_err_o     <= 1'b0;
         start_err_o   <= 1'b0;
      end else begin
         len_err_o   <= 1'b0;
         start_err_o <= 1'b0;
         // A completed handshake empties the register unless a load below refills it.
         if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (tx_start_i) begin
                  if ((len_words_i == 8'd0) || (len_words_i > MAX_LEN)) begin
                     start_err_o <= 1'b1;
                  end else begin
                     src_mac_q  <= src_mac_i;
                     dst_mac_q  <= dst_mac_i;
                     src_ip_q   <= src_ip_i;
                     dst_ip_q   <= dst_ip_i;
                     src_port_q <= src_port_i;
                     dst_port_q <= dst_port_i;
                     ip_id_q    <= ip_id_i;
                     len_q      <= len_words_i;
                     pay_rem    <= len_words_i;
                     busy_o     <= 1'b1;
                     state      <= ST_CSUM0;
                  end
               end
            end
            ST_CSUM0: state <= ST_CSUM1;
            ST_CSUM1: begin
               hdr_idx <= 3'd0;
               state   <= ST_HDR;
            end
            ST_HDR: begin
               if (adv) begin
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= hdr_word;
                  m_axis_tstrb  <= 8'hFF;
                  m_axis_tlast  <= 1'b0;
                  hdr_idx       <= hdr_idx + 3'd1;
                  if (hdr_idx == 3'd4) state <= ST_MIX;
               end
            end
            ST_MIX, ST_PAY: begin
               if (pay_fire) begin
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= {s_axis_tdata[47:0],
                                    (state == ST_MIX) ? hdr_le[HDR_BYTES*8-1 -: 16] : prev_q};
                  m_axis_tstrb  <= 8'hFF;
                  m_axis_tlast  <= 1'b0;
                  prev_q        <= s_axis_tdata[63:48];
                  pay_rem       <= pay_rem - 8'd1;
                  if (s_axis_tlast != pay_last) len_err_o <= 1'b1;
                  state         <= pay_last ? ST_TAIL : ST_PAY;
               end
            end
            ST_TAIL: begin
               // tlast in the register marks that the tail word is already loaded.
               if (m_axis_tvalid && m_axis_tlast) begin
                  if (m_axis_tready) begin
                     busy_o <= 1'b0;
                     state  <= ST_IDLE;
                  end
               end else if (adv) begin
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= {48'd0, prev_q};
                  m_axis_tstrb  <= 8'h03;
                  m_axis_tlast  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_udp_tx.sv
module tb_axis_udp_tx;

   logic        clk;
   logic        arst_n;
   logic        tx_start;
   logic [7:0]  len_words;
   logic [47:0] src_mac, dst_mac;
   logic [31:0] src_ip, dst_ip;
   logic [15:0] src_port, dst_port, ip_id;
   logic        s_tvalid, s_tlast, s_tready;
   logic [63:0] s_tdata;
   logic [7:0]  s_tstrb;
   logic        m_tvalid, m_tlast, m_tready;
   logic [63:0] m_tdata;
   logic [7:0]  m_tstrb;
   logic        busy, len_err, start_err;

   axis_udp_tx #(.MAX_PAYLOAD_WORDS(182)) dut (
      .clk_i         (clk),
      .arst_n_i      (arst_n),
      .tx_start_i    (tx_start),
      .len_words_i   (len_words),
      .src_mac_i     (src_mac),
      .dst_mac_i     (dst_mac),
      .src_ip_i      (src_ip),
      .dst_ip_i      (dst_ip),
      .src_port_i    (src_port),
      .dst_port_i    (dst_port),
      .ip_id_i       (ip_id),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tdata  (s_tdata),
      .s_axis_tstrb  (s_tstrb),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tdata  (m_tdata),
      .m_axis_tstrb  (m_tstrb),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready),
      .busy_o        (busy),
      .len_err_o     (len_err),
      .start_err_o   (start_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } word_t;

   typedef struct {
      logic [63:0] data;
      logic        last;
   } beat_t;

   typedef struct {
      int          n;
      bit          rnd;
      bit          pat_rand;
      int          early;
      bit          drop_last;
      int          exp_words;
      int          exp_lerr;
      logic [15:0] id;
   } vec_t;

   word_t exp_q[$];
   word_t obs[$];
   beat_t pay_q[$];
   word_t held, e;
   int    n_chk = 0;
   int    n_fail = 0;
   int    lerr_cnt = 0;
   bit    rnd_ready = 1'b0;
   bit    hs_s = 1'b0;
   bit    stall_prev = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Payload source and output back-pressure, driven just after each edge.
   initial begin
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tstrb  = '0;
      s_tlast  = 1'b0;
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (hs_s && pay_q.size() > 0) pay_q.delete(0);
         if (pay_q.size() > 0) begin
            s_tvalid = 1'b1;
            s_tdata  = pay_q[0].data;
            s_tlast  = pay_q[0].last;
         end else begin
            s_tvalid = 1'b0;
            s_tdata  = '0;
            s_tlast  = 1'b0;
         end
         s_tstrb  = 8'($urandom);
         m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor / scoreboard, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         hs_s = s_tvalid && s_tready;
         if (len_err) lerr_cnt++;
         if (!arst_n) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               chk("stall_tvalid", 64'(m_tvalid), 64'd1);
               chk("stall_tdata", m_tdata, held.data);
               chk("stall_tstrb_tlast", 64'({m_tstrb, m_tlast}), 64'({held.strb, held.last}));
            end
            stall_prev = m_tvalid && !m_tready;
            held.data = m_tdata;
            held.strb = m_tstrb;
            held.last = m_tlast;
            if (m_tvalid && m_tready) begin
               obs.push_back(held);
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_word: actual=0x%0h required=none", m_tdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("word_data", m_tdata, e.data);
                  chk("word_strb", 64'(m_tstrb), 64'(e.strb));
                  chk("word_last", 64'(m_tlast), 64'(e.last));
               end
            end
         end
      end
   end

   function automatic logic [15:0] ref_csum(input logic [15:0] tot, input logic [15:0] id,
                                            input logic [31:0] sip, input logic [31:0] dip);
      logic [31:0] s;
      s = 32'h4500 + 32'(tot) + 32'(id) + 32'h4000 + 32'h4011
        + 32'(sip[31:16]) + 32'(sip[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0]);
      while (s > 32'h0000FFFF) s = (s & 32'h0000FFFF) + (s >> 16);
      return ~s[15:0];
   endfunction

   // Reference model: byte stream of header + payload, cut into 8-byte words.
   task automatic queue_frame(input int n, input bit pat_rand, input int early, input bit drop_last);
      logic [7:0]  bq[$];
      logic [63:0] p;
      logic [15:0] tot, ulen, cs;
      beat_t       bt;
      word_t       w;
      int          nw;
      tot  = 16'(28 + 8 * n);
      ulen = 16'(8 + 8 * n);
      cs   = ref_csum(tot, ip_id, src_ip, dst_ip);
      for (int i = 5; i >= 0; i--) bq.push_back(dst_mac[8*i +: 8]);
      for (int i = 5; i >= 0; i--) bq.push_back(src_mac[8*i +: 8]);
      bq.push_back(8'h08); bq.push_back(8'h00); bq.push_back(8'h45); bq.push_back(8'h00);
      bq.push_back(tot[15:8]); bq.push_back(tot[7:0]);
      bq.push_back(ip_id[15:8]); bq.push_back(ip_id[7:0]);
      bq.push_back(8'h40); bq.push_back(8'h00); bq.push_back(8'd64); bq.push_back(8'd17);
      bq.push_back(cs[15:8]); bq.push_back(cs[7:0]);
      for (int i = 3; i >= 0; i--) bq.push_back(src_ip[8*i +: 8]);
      for (int i = 3; i >= 0; i--) bq.push_back(dst_ip[8*i +: 8]);
      bq.push_back(src_port[15:8]); bq.push_back(src_port[7:0]);
      bq.push_back(dst_port[15:8]); bq.push_back(dst_port[7:0]);
      bq.push_back(ulen[15:8]); bq.push_back(ulen[7:0]);
      bq.push_back(8'h00); bq.push_back(8'h00);
      for (int k = 0; k < n; k++) begin
         p = pat_rand ? {$urandom, $urandom}
                      : 64'h0706050403020100 + 64'(k) * 64'h0808080808080808;
         bt.data = p;
         bt.last = ((k == n - 1) && !drop_last) || (k == early);
         pay_q.push_back(bt);
         for (int b = 0; b < 8; b++) bq.push_back(p[8*b +: 8]);
      end
      nw = (bq.size() + 7) / 8;
      for (int wi = 0; wi < nw; wi++) begin
         w.data = '0;
         w.strb = '0;
         for (int b = 0; b < 8; b++) begin
            if (8 * wi + b < bq.size()) begin
               w.data[8*b +: 8] = bq[8*wi + b];
               w.strb[b] = 1'b1;
            end
         end
         w.last = (wi == nw - 1);
         exp_q.push_back(w);
      end
   endtask

   task automatic set_cfg(input logic [15:0] id);
      src_mac  = {$urandom, $urandom};
      dst_mac  = {$urandom, $urandom};
      src_ip   = 32'hC0A8010A;
      dst_ip   = 32'hC0A80114;
      src_port = 16'($urandom);
      dst_port = 16'($urandom);
      ip_id    = id;
   endtask

   task automatic start_frame(input logic [7:0] len);
      @(posedge clk);
      #1;
      len_words = len;
      tx_start  = 1'b1;
      @(posedge clk);
      #1;
      tx_start  = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      int c;
      for (c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) break;
      end
      chk("frame_done_in_time", 64'(c < max_cyc), 64'd1);
   endtask

   task automatic run_vec(input vec_t v);
      rnd_ready = v.rnd;
      set_cfg(v.id);
      obs.delete();
      lerr_cnt = 0;
      queue_frame(v.n, v.pat_rand, v.early, v.drop_last);
      start_frame(8'(v.n));
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("first_valid_latency", 64'(m_tvalid), 64'(c == 3));
         if (c == 0) chk("busy_after_accept", 64'(busy), 64'd1);
         if (c < 3) @(posedge clk);
      end
      wait_done(3000);
      chk("frame_words", 64'(obs.size()), 64'(v.exp_words));
      chk("len_err_pulses", 64'(lerr_cnt), 64'(v.exp_lerr));
      rnd_ready = 1'b0;
   endtask

   vec_t vecs[6];
   int   bad_lens[2];

   initial begin
      arst_n    = 1'b0;
      tx_start  = 1'b0;
      len_words = '0;
      set_cfg(16'h0000);

      vecs[0] = '{n:1,   rnd:0, pat_rand:0, early:-1, drop_last:0, exp_words:7,   exp_lerr:0, id:16'h0000};
      vecs[1] = '{n:4,   rnd:0, pat_rand:0, early:-1, drop_last:0, exp_words:10,  exp_lerr:0, id:16'h1234};
      vecs[2] = '{n:3,   rnd:0, pat_rand:0, early:1,  drop_last:0, exp_words:9,   exp_lerr:1, id:16'hBEEF};
      vecs[3] = '{n:182, rnd:1, pat_rand:1, early:-1, drop_last:0, exp_words:188, exp_lerr:0, id:16'hFFFF};
      vecs[4] = '{n:5,   rnd:1, pat_rand:1, early:-1, drop_last:1, exp_words:11,  exp_lerr:1, id:16'h0042};
      vecs[5] = '{n:2,   rnd:0, pat_rand:1, early:-1, drop_last:0, exp_words:8,   exp_lerr:0, id:16'h8000};
      bad_lens[0] = 0;
      bad_lens[1] = 183;

      #1;
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      chk("rst_busy_errs", 64'({busy, len_err, start_err}), 64'd0);
      chk("rst_m_tdata", m_tdata, 64'd0);
      repeat (3) @(negedge clk);
      arst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i]);
         if (i == 0) begin
            chk("ip_total_len", 64'({obs[2].data[7:0], obs[2].data[15:8]}), 64'h0024);
            chk("ip_checksum", 64'({obs[3].data[7:0], obs[3].data[15:8]}), 64'hB75A);
            chk("udp_len", 64'({obs[4].data[55:48], obs[4].data[63:56]}), 64'h0010);
            chk("last_tstrb", 64'(obs[6].strb), 64'h03);
         end
         if (i == 1) begin
            chk("mix_hdr_bytes", 64'(obs[5].data[15:0]), 64'h0000);
            chk("mix_pay_bytes01", 64'(obs[5].data[31:16]), 64'h0100);
            chk("tail_tdata", 64'(obs[9].data[15:0]), 64'h1F1E);
         end
      end

      // Out-of-range lengths are rejected with a single start_err pulse.
      for (int i = 0; i < 2; i++) begin
         start_frame(8'(bad_lens[i]));
         @(negedge clk);
         chk("start_err_pulse", 64'(start_err), 64'd1);
         chk("start_err_busy", 64'(busy), 64'd0);
         @(negedge clk);
         chk("start_err_single", 64'(start_err), 64'd0);
         chk("start_err_no_frame", 64'({busy, m_tvalid}), 64'd0);
      end

      // Start while busy is ignored; extra payload beyond N stays unconsumed.
      set_cfg(16'h0777);
      obs.delete();
      queue_frame(3, 1'b1, -1, 1'b0);
      pay_q.push_back('{data: 64'hDEAD_BEEF_0000_0001, last: 1'b1});
      start_frame(8'd3);
      repeat (4) @(posedge clk);
      #1;
      len_words = 8'd5;
      tx_start  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tx_start  = 1'b0;
      wait_done(500);
      chk("busy_start_frame_words", 64'(obs.size()), 64'd9);
      repeat (6) @(negedge clk);
      chk("busy_start_ignored", 64'({busy, m_tvalid}), 64'd0);
      chk("payload_beyond_n_kept", 64'(pay_q.size()), 64'd1);
      pay_q.delete();

      // Reset during PAY drops every output immediately.
      set_cfg(16'h0101);
      obs.delete();
      queue_frame(8, 1'b1, -1, 1'b0);
      start_frame(8'd8);
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (obs.size() >= 7) break;
      end
      chk("reached_pay", 64'(obs.size() >= 7), 64'd1);
      @(posedge clk);
      #2;
      arst_n = 1'b0;
      #1;
      chk("rst_mid_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_mid_s_tready", 64'(s_tready), 64'd0);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_tdata", m_tdata, 64'd0);
      chk("rst_mid_tlast_tstrb", 64'({m_tlast, m_tstrb}), 64'd0);
      chk("rst_mid_errs", 64'({len_err, start_err}), 64'd0);
      exp_q.delete();
      pay_q.delete();
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      run_vec(vecs[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: actual=timeout required=finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
